// File: rtl/bcd4_display_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with a BCD snapshot,
// leading-zero blanking, invalid-digit dash and a sticky overflow decimal point.
module bcd4_display_mux #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       load,
  input  logic       blank_lz,
  input  logic       ovf_in,
  input  logic       clear,
  input  logic [3:0] d33_d30,
  input  logic [3:0] d23_d20,
  input  logic [3:0] d13_d10,
  input  logic [3:0] d03_d00,
  output logic [3:0] an3_an0,
  output logic [6:0] seg6_seg0,
  output logic       dp_
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [15:0]     snap_q, snap_d;
  logic            ovf_q, ovf_d;
  logic            blank_q, blank_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;
    // blank_lz is registered so no input reaches the outputs combinationally.
    blank_d = blank_lz;

    case (state_q)
      SHOW: begin
        if (pre_q == PRE_LAST) begin
          state_d = GAP;
          pre_d   = '0;
          idx_d   = idx_q + 2'd1;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      GAP:     state_d = SHOW;
      default: state_d = SHOW;
    endcase

    if (load) snap_d = {d33_d30, d23_d20, d13_d10, d03_d00};

    // Set has priority over clear.
    if (ovf_in)     ovf_d = 1'b1;
    else if (clear) ovf_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= SHOW;
      idx_q   <= 2'd0;
      pre_q   <= '0;
      snap_q  <= 16'h0000;
      ovf_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      blank_q <= blank_d;
    end
  end

  logic [3:0] cur_dig;
  logic       lz3, lz2, lz1;
  logic       blank_dig;

  always_comb begin
    lz3 = (snap_q[15:12] == 4'd0);
    lz2 = lz3 && (snap_q[11:8] == 4'd0);
    lz1 = lz2 && (snap_q[7:4] == 4'd0);

    cur_dig   = snap_q[3:0];
    blank_dig = 1'b0;
    case (idx_q)
      2'd0: cur_dig = snap_q[3:0];
      2'd1: begin cur_dig = snap_q[7:4];   blank_dig = lz1; end
      2'd2: begin cur_dig = snap_q[11:8];  blank_dig = lz2; end
      2'd3: begin cur_dig = snap_q[15:12]; blank_dig = lz3; end
      default: cur_dig = snap_q[3:0];
    endcase

    an3_an0   = 4'b1111;
    seg6_seg0 = 7'b1111111;
    dp_       = 1'b1;
    if (state_q == SHOW) begin
      an3_an0   = ~(4'b0001 << idx_q);
      seg6_seg0 = (blank_q && blank_dig) ? 7'b1111111 : seg_decode(cur_dig);
      dp_       = ~((idx_q == 2'd3) && ovf_q);
    end
  end

endmodule

// File: tb/tb_bcd4_display_mux.sv
// Self-checking bench for bcd4_display_mux: directed scenarios followed by random
// stimulus, compared every cycle against a slot-position reference model.
module tb_bcd4_display_mux;

  localparam int S = 4;
  localparam int P = 4 * (S + 1);

  logic       clock = 1'b0;
  logic       reset_ = 1'b1;
  logic       load = 1'b0;
  logic       blank_lz = 1'b0;
  logic       ovf_in = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  bcd4_display_mux #(.SCAN_DIV(S)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .load      (load),
    .blank_lz  (blank_lz),
    .ovf_in    (ovf_in),
    .clear     (clear),
    .d33_d30   (d3),
    .d23_d20   (d2),
    .d13_d10   (d1),
    .d03_d00   (d0),
    .an3_an0   (an),
    .seg6_seg0 (seg),
    .dp_       (dp)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: cycle position within a full scan plus the captured digits.
  int t;
  int dig[4];
  bit flag;
  bit blank_m;
  logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int j = 0; j < 4; j++) dig[j] = 0;
    flag = 1'b0;
    blank_m = 1'b0;
  endtask

  task automatic check_outputs();
    int pos = t % P;
    int k = pos / (S + 1);
    int w = pos % (S + 1);
    bit lead = 1'b1;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp;
    if (w == S) begin
      ean = 4'b1111; eseg = 7'b1111111; edp = 1'b1;
    end else begin
      for (int j = 3; j >= k; j--) if (dig[j] != 0) lead = 1'b0;
      ean = 4'b1111;
      ean[k] = 1'b0;
      if (blank_m && k > 0 && lead) eseg = 7'b1111111;
      else if (dig[k] < 10)         eseg = seg_tab[dig[k]];
      else                          eseg = 7'b0111111;
      edp = !(k == 3 && flag);
    end
    check("an", an, ean);
    check("seg", seg, eseg);
    check("dp", dp, edp);
  endtask

  // Check at the falling edge, then advance the model with the inputs the DUT sees.
  task automatic tick();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    t = (t + 1) % P;
    if (load) begin
      dig[3] = d3; dig[2] = d2; dig[1] = d1; dig[0] = d0;
    end
    if (ovf_in)     flag = 1'b1;
    else if (clear) flag = 1'b0;
    blank_m = blank_lz;
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    #1;
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_dp", dp, 1'b1);
    model_reset();
    @(posedge clock);
    #1;
    reset_ = 1'b1;
  endtask

  task automatic wait_slot(input int k, input int w, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 2 * P; i++) begin
      if ((t % P) / (S + 1) == k && (t % P) % (S + 1) == w) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(tag, found, 1'b1);
  endtask

  task automatic set_digits(input int a3, input int a2, input int a1, input int a0);
    d3 = 4'(a3); d2 = 4'(a2); d1 = 4'(a1); d0 = 4'(a0);
  endtask

  function automatic logic [3:0] rand_digit();
    return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    #2;
    do_reset();

    // Scan timing with digits 1,2,3,4
    set_digits(1, 2, 3, 4);
    load = 1'b1; tick(); load = 1'b0;
    repeat (2 * P) tick();

    // Reset in the middle of digit 2's slot
    wait_slot(2, 1, "find_d2_mid");
    do_reset();
    repeat (P) tick();

    // Leading-zero blanking
    blank_lz = 1'b1;
    set_digits(0, 0, 7, 0);
    load = 1'b1; tick(); load = 1'b0;
    repeat (P) tick();
    set_digits(0, 0, 0, 0);
    load = 1'b1; tick(); load = 1'b0;
    repeat (P) tick();
    blank_lz = 1'b0;
    repeat (P) tick();

    // Invalid digit and snapshot hold
    set_digits(5, 0, 9, 12);
    load = 1'b1; tick(); load = 1'b0;
    repeat (P + 2) begin
      set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      tick();
    end

    // Overflow set, set+clear together, then clear during digit 3
    ovf_in = 1'b1; tick(); ovf_in = 1'b0;
    repeat (2 * P) tick();
    ovf_in = 1'b1; clear = 1'b1; tick(); ovf_in = 1'b0; clear = 1'b0;
    repeat (P) tick();
    wait_slot(3, 1, "find_d3");
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (P) tick();

    // Load on the edge that enters the gap after digit 1
    wait_slot(1, S - 1, "find_d1_end");
    set_digits(8, 6, 9, 2);
    load = 1'b1; tick(); load = 1'b0;
    repeat (P) tick();

    // Random stimulus
    repeat (1500) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
      load   = ($urandom_range(0, 7) == 0);
      ovf_in = ($urandom_range(0, 31) == 0);
      clear  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
